// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  function automatic req_idx_t onehot2idx(input logic [MAX_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter, bundled as one interface.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;

  modport master (
    output req, req_data, req_last, fifo_full,
    input  gnt, fifo_wr_en, fifo_data_in
  );

  modport slave (
    input  req, req_data, req_last, fifo_full,
    output gnt, fifo_wr_en, fifo_data_in
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible request at or after rr_ptr, wrapping.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  req_idx_t           rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           gnt_idx,
  output logic               any_gnt
);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] low;
  logic [MAX_REQ-1:0] gnt_ext;

  assign elig    = req & mask;
  assign any_gnt = |elig;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  assign rot = NUM_REQ'({elig, elig} >> rr_ptr);
  assign low = rot & (~rot + 1'b1);
  assign gnt = NUM_REQ'(({low, low} << rr_ptr) >> NUM_REQ);

  always_comb begin
    gnt_ext = '0;
    gnt_ext[NUM_REQ-1:0] = gnt;
  end

  assign gnt_idx = onehot2idx(gnt_ext);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one sync_fifo write port behind a one-entry output stage.
// Optional packet lock is enabled with `define FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input logic          clk,
  input logic          n_rst,
  fifo_wr_arbiter_if.slave bus
);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  req_idx_t              rr_ptr;
  req_idx_t              gnt_idx;
  req_idx_t              next_ptr;
  logic                  stage_ready;
  logic                  any_gnt;
  logic [NUM_REQ-1:0]    lock_mask;
  logic [NUM_REQ-1:0]    arb_mask;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] sel_data;

  assign stage_ready = ~out_valid | ~bus.fifo_full;
  // No grant while the stage is blocked or reset is asserted.
  assign arb_mask    = (n_rst && stage_ready) ? lock_mask : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (bus.req),
    .mask    (arb_mask),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign next_ptr = (gnt_idx == req_idx_t'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (any_gnt) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      rr_ptr    <= next_ptr;
    end else if (bus.fifo_wr_en) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  logic     lock;
  req_idx_t lock_id;
  logic     sel_last;

  assign sel_last = |(bus.req_last & gnt);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lock_mask[i] = ~lock | (lock_id == req_idx_t'(i));
    end
  end

  // A beat without last opens (or continues) a packet on that requester.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (any_gnt) begin
      lock    <= ~sel_last;
      lock_id <= gnt_idx;
    end
  end
`else
  logic unused_last;

  assign lock_mask   = '1;
  assign unused_last = ^bus.req_last;
`endif

  assign bus.gnt          = gnt;
  assign bus.fifo_wr_en   = out_valid & ~bus.fifo_full;
  assign bus.fifo_data_in = out_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] wr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one-entry stage, pointer as an integer, lock as owner id.
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_ptr;
  bit            m_lock;
  int            m_lock_id;
  logic [N-1:0]  e_gnt;
  int            e_idx;
  bit            e_wr;

  initial begin
    int j;
    m_valid = 0; m_data = '0; m_ptr = 0; m_lock = 0; m_lock_id = 0;
    forever begin
      @(negedge clk);
      e_wr  = m_valid && !bus.fifo_full;
      e_gnt = '0;
      e_idx = -1;
      if (n_rst && (!m_valid || !bus.fifo_full)) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (e_idx < 0 && bus.req[j] && (!LOCK_EN || !m_lock || j == m_lock_id)) e_idx = j;
        end
      end
      if (e_idx >= 0) e_gnt[e_idx] = 1'b1;
      if (chk_en) begin
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
        check("data_in", 32'(bus.fifo_data_in), 32'(m_data));
      end
      if (bus.fifo_wr_en === 1'b1) wr_log.push_back(bus.fifo_data_in);
      @(posedge clk);
      if (!n_rst) begin
        m_valid = 0; m_data = '0; m_ptr = 0; m_lock = 0; m_lock_id = 0;
      end else if (e_idx >= 0) begin
        m_valid = 1;
        m_data  = bus.req_data[e_idx*DW +: DW];
        m_ptr   = (e_idx + 1) % N;
        if (LOCK_EN) begin
          m_lock    = !bus.req_last[e_idx];
          m_lock_id = e_idx;
        end
      end else if (e_wr) begin
        m_valid = 0;
      end
    end
  end

  initial begin
    logic [DW-1:0] exp5 [5];
    logic [N-1:0]  g;
    logic [N-1:0]  t4_exp [3];
    int ngr;
    int beat;
    bit g1;

    bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst  = 1'b1;
    chk_en = 1'b1;
    settle();
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_wr", 32'(bus.fifo_wr_en), 32'h0);
    next_cycle();

    // Reset while a beat is held behind a full FIFO.
    bus.req = 4'b0010; bus.req_data[15:8] = 8'h55;
    settle(); next_cycle();
    bus.req = '0; bus.fifo_full = 1'b1;
    settle();
    check("t1_held_wr", 32'(bus.fifo_wr_en), 32'h0);
    next_cycle();
    n_rst = 1'b0;
    settle();
    check("t1_rst_gnt", 32'(bus.gnt), 32'h0);
    next_cycle();
    n_rst = 1'b1; bus.fifo_full = 1'b0;
    wr_log.delete();
    settle();
    check("t1_post_wr", 32'(bus.fifo_wr_en), 32'h0);
    check("t1_log_empty", 32'(wr_log.size()), 32'h0);
    next_cycle();

    // Round-robin with all requesters active; also pins rr_ptr=0 after reset.
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    wr_log.delete();
    for (int c = 0; c < 8; c++) begin
      settle();
      check("t2_gnt", 32'(bus.gnt), 32'(1 << (c % 4)));
      if (c == 0) check("t2_first_wr", 32'(bus.fifo_wr_en), 32'h0);
      if (c == 1) check("t2_latency", 32'(bus.fifo_wr_en), 32'h1);
      next_cycle();
    end
    bus.req = '0;
    settle(); next_cycle();
    check("t2_count", 32'(wr_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++)
      check("t2_order", 32'(wr_log[k]), 32'(8'hA0 + 8'(k % 4)));

    // Backpressure with two requesters.
    bus.req = 4'b0011; bus.req_data[7:0] = 8'hB0; bus.req_data[15:8] = 8'hB1;
    bus.fifo_full = 1'b1;
    wr_log.delete();
    ngr = 0;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (bus.gnt != '0) ngr++;
      if (c == 0) check("t3_first_gnt", 32'(bus.gnt), 32'h1);
      else check("t3_wr_off", 32'(bus.fifo_wr_en), 32'h0);
      next_cycle();
    end
    check("t3_one_accept", 32'(ngr), 32'd1);
    bus.fifo_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c == 0) begin
        check("t3_resume_wr", 32'(bus.fifo_wr_en), 32'h1);
        check("t3_resume_gnt", 32'(bus.gnt), 32'h2);
      end
      next_cycle();
    end
    bus.req = '0;
    settle(); next_cycle();
    check("t3_count", 32'(wr_log.size()), 32'd5);
    if (wr_log.size() >= 3) begin
      check("t3_w0", 32'(wr_log[0]), 32'hB0);
      check("t3_w1", 32'(wr_log[1]), 32'hB1);
      check("t3_w2", 32'(wr_log[2]), 32'hB0);
    end

    // Wrap and skip from rr_ptr=3.
    bus.req = 4'b0100; bus.req_data[23:16] = 8'h44;
    settle(); next_cycle();
    bus.req = 4'b0101; bus.req_data[7:0] = 8'h40;
    t4_exp[0] = 4'b0001; t4_exp[1] = 4'b0100; t4_exp[2] = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t4_gnt", 32'(bus.gnt), 32'(t4_exp[c]));
      next_cycle();
    end

    // Drain and accept in the same cycle.
    bus.req = 4'b1000; bus.req_data[31:24] = 8'h88;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("t6_gnt", 32'(bus.gnt), 32'h8);
      check("t6_wr", 32'(bus.fifo_wr_en), 32'h1);
      next_cycle();
    end

    // Three-beat packet from requester 1 against a continuous requester 0.
    bus.req = 4'b0001; bus.req_data[7:0] = 8'hD0; bus.req_last = '0;
    settle(); next_cycle();
    bus.req = 4'b0011; bus.req_data[15:8] = 8'hC1; bus.req_last = 4'b0000;
    beat = 1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (c == 0) wr_log.delete();
      g1 = bus.gnt[1];
      next_cycle();
      if (g1) begin
        beat++;
        if (beat > 3) bus.req[1] = 1'b0;
        else begin
          bus.req_data[15:8] = 8'hC0 + 8'(beat);
          bus.req_last[1]    = (beat == 3);
        end
      end
    end
    bus.req = '0; bus.req_last = '0;
    settle(); next_cycle();
    if (LOCK_EN) begin
      exp5[0] = 8'hC1; exp5[1] = 8'hC2; exp5[2] = 8'hC3; exp5[3] = 8'hD0; exp5[4] = 8'hD0;
    end else begin
      exp5[0] = 8'hC1; exp5[1] = 8'hD0; exp5[2] = 8'hC2; exp5[3] = 8'hD0; exp5[4] = 8'hC3;
    end
    check("t5_count_min", 32'(wr_log.size() >= 5), 32'h1);
    for (int k = 0; k < 5 && k < wr_log.size(); k++)
      check("t5_order", 32'(wr_log[k]), 32'(exp5[k]));

    // Random traffic with drops, backpressure and one mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      settle();
      g = bus.gnt;
      next_cycle();
      n_rst = (c != 1500);
      for (int i = 0; i < N; i++) begin
        if (g[i] || !bus.req[i]) begin
          if ($urandom_range(3) != 0) begin
            bus.req[i]               = 1'b1;
            bus.req_data[i*DW +: DW] = 8'($urandom);
            bus.req_last[i]          = ($urandom_range(2) == 0);
          end else begin
            bus.req[i] = 1'b0;
          end
        end else if ($urandom_range(15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.fifo_full = ($urandom_range(2) == 0);
    end
    n_rst = 1'b1; bus.req = '0; bus.fifo_full = 1'b0;
    repeat (3) begin
      settle(); next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
